// File: rtl/wn_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : wn_addr_gen
// Brief    : Twiddle ROM address generator for one radix-2 SDF FFT stage.
// Revision : 1.0 - initial release
// ============================================================================
module wn_addr_gen #(
   parameter int width   = 16,
   parameter int addrw   = 6,
   parameter int STAGE   = 0,
   parameter int ROM_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic             inv,
   output logic [addrw-1:0] addr_re,
   output logic [addrw-1:0] addr_im,
   output logic             tw_valid,
   output logic             neg_im,
   output logic             tw_last,
   output logic             frame_done,
   output logic             busy
);

   localparam int              c_dly     = 1 + ROM_LAT;
   localparam int              c_jw      = addrw - STAGE;
   localparam logic [addrw:0]  c_cnt_max = '1;

   generate
      if (STAGE < 0 || STAGE >= addrw || ROM_LAT < 1 || width < 1) begin : g_param_check
         $error("wn_addr_gen: illegal parameter combination");
      end
   endgenerate

   logic [addrw:0]   r_cnt;
   logic [addrw:0]   w_cnt_nxt;
   logic [c_jw-1:0]  w_j;
   logic             w_phase;
   logic             w_accept;
   logic             w_last_smp;
   logic [addrw-1:0] w_addr_nxt;
   logic [addrw-1:0] r_addr;
   logic [c_dly-1:0] r_vld_dly;
   logic [c_dly-1:0] r_neg_dly;
   logic [c_dly-1:0] r_last_dly;
   logic             r_frame_done;
   logic             r_busy;

   // Upper half of each 2^(addrw+1-STAGE) block uses W^(j*2^STAGE); lower half W^0.
   always_comb begin
      w_j        = r_cnt[c_jw-1:0];
      w_phase    = r_cnt[c_jw];
      w_addr_nxt = w_phase ? (addrw'(w_j) << STAGE) : '0;
      w_accept   = in_valid & ~start;
      w_last_smp = w_accept & (r_cnt == c_cnt_max);
      w_cnt_nxt  = r_cnt;
      if (start) begin
         w_cnt_nxt = '0;
      end else if (in_valid) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_addr       <= '0;
         r_vld_dly    <= '0;
         r_neg_dly    <= '0;
         r_last_dly   <= '0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_busy       <= (w_cnt_nxt != '0);
         r_frame_done <= w_last_smp;
         // start flushes every in-flight sample, including one arriving with it
         if (start) begin
            r_addr     <= '0;
            r_vld_dly  <= '0;
            r_neg_dly  <= '0;
            r_last_dly <= '0;
         end else begin
            if (in_valid) begin
               r_addr <= w_addr_nxt;
            end
            r_vld_dly  <= (r_vld_dly  << 1) | c_dly'(in_valid);
            r_neg_dly  <= (r_neg_dly  << 1) | c_dly'(in_valid & inv);
            r_last_dly <= (r_last_dly << 1) | c_dly'(w_last_smp);
         end
      end
   end

   assign addr_re    = r_addr;
   assign addr_im    = r_addr;
   assign tw_valid   = r_vld_dly[c_dly-1];
   assign neg_im     = r_neg_dly[c_dly-1];
   assign tw_last    = r_last_dly[c_dly-1];
   assign frame_done = r_frame_done;
   assign busy       = r_busy;

endmodule
`default_nettype wire
